if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that drives the IF/ID pipeline register's fetch_instruction and IF_PCjia4 inputs.
- Owns the PC and issues word fetches to instruction memory over a req/ready handshake.
- Honours the hazard unit's keep (stall) and the branch/jump redirect; the redirect is the same event that flushes IF/ID.
- A one-entry output buffer plus a one-entry skid register absorb a stall that arrives while a fetch is completing.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- keep  in  1  stall; IF/ID does not load this edge, so the output buffer is not consumed.
- redirect  in  1  taken branch/jump; discard every fetch younger than the redirect.
- redirect_pc  in  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req  out  1  fetch request; held high with imem_addr stable until imem_ready.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  memory completes the request this cycle; imem_rdata valid.
- imem_rdata  in  32  instruction word.
- fetch_instruction  out  32  to IF/ID; 32'h0 (nop) when buffer empty.
- IF_PCjia4  out  32  address of presented instruction + 4; 32'h0 when buffer empty.
- fetch_valid  out  1  buffer holds a real instruction (for debug/perf).

Behaviour:
- State registers: state ∈ {REQ, HOLD, DRAIN}; pc; pending_pc; buf_valid, buf_instr, buf_pc4; skid_instr, skid_pc4.
- Reset (reset==0 at posedge): state=REQ, pc=pending_pc=RESET_PC, buf_valid=0, buf/skid fields=0.
- While reset==0, imem_req is forced to 0. Visible outputs during reset: fetch_instruction=0, IF_PCjia4=0, fetch_valid=0.
- The same reset also resets imem, so an abandoned request needs no completion.
- imem_req=1 in REQ and DRAIN; imem_req=0 in HOLD. imem_addr=pc at all times.
- Outputs are combinational from the buffer: fetch_instruction = buf_valid ? buf_instr : 0. IF_PCjia4 and fetch_valid follow buf_valid the same way.
- free = !buf_valid || !keep. The buffer is consumed or empty at this edge.
- Priority at each edge: reset > redirect > normal operation. Redirect beats keep, mirroring IF/ID flush over keep.
- REQ, no redirect:
  - ready && free: buf ← {1, rdata, pc+4}; pc ← pc+4; stay REQ. This gives back-to-back fetches, 1 instruction/cycle with a zero-wait memory.
  - ready && !free: skid ← {rdata, pc+4}; pc ← pc+4; → HOLD.
  - !ready: if free, buf_valid ← 0; hold pc.
- HOLD, no redirect: if !keep, buf ← {1, skid}, → REQ; else hold everything.
- DRAIN: the outstanding request at the old pc completes and its data is discarded. On ready: pc ← pending_pc, → REQ; buf stays empty.
- Redirect (any state): buf_valid ← 0; skid discarded.
  - REQ && !ready: pending_pc ← redirect_pc, → DRAIN. The address stays stable, satisfying the handshake.
  - REQ && ready, or HOLD: pc ← redirect_pc, → REQ. The first redirected request is issued next cycle.
  - DRAIN && !ready: pending_pc ← redirect_pc (latest wins).
  - DRAIN && ready: pc ← redirect_pc, → REQ.
- Arithmetic: pc+4 is 32-bit modulo (0xFFFF_FFFC → 0x0000_0000); no alignment traps.
- Redirect penalty with a zero-wait memory: the redirected instruction is presented 1 cycle after the redirect edge, plus imem latency.
- No instruction is ever duplicated or dropped except those younger than a redirect.

Decomposition:
- Shared pipeline package holds:
  - state encoding (FETCH_REQ, FETCH_HOLD, FETCH_DRAIN);
  - NOP_INSTR = 32'h0;
  - PC_STEP = 4;
  - DEFAULT_RESET_PC.
- One sub-module is natural: fetch_skid_buf. It contains the buf/skid register pair with load/consume/clear controls, so the FSM and PC logic stay in the top.

Test Plan:
- Reset release, zero-wait imem (ready=1 always), keep=0: addr 0,4,8 on consecutive cycles; IF_PCjia4 = 4,8,12 one cycle behind each address; fetch_valid=1 from cycle 2.
- keep=1 for 3 cycles while ready=1 with buf full: state → HOLD, imem_req=0; fetch_instruction is stable on the buffered word. After keep falls, the skid word is presented next and no word is lost or repeated.
- 2-wait-state imem, redirect to 0x100 in the first wait cycle: imem_addr stays at the old pc until ready; that data is discarded (fetch_valid=0). The next request is at 0x100 and IF_PCjia4 = 0x104.
- Redirect to 0x200 with keep=1 in the same cycle while in HOLD: buf and skid are cleared and the output reads 0/0. The next fetch is at 0x200.
- Two redirects, to 0x300 then 0x400, during one DRAIN: the next issued address is 0x400.
- Redirect to 0xFFFF_FFFC: the following fetch is at 0x0000_0000 with IF_PCjia4 = 0x0. Assert reset mid-REQ: imem_req drops in that cycle and the first request after release is at RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// rtl/if_fetch_unit_pkg.sv - shared fetch-stage state encoding, constants and helpers
package if_fetch_unit_pkg;

  // Fetch FSM: issuing requests, parked with a full buffer+skid, or draining a
  // request that a redirect made stale.
  typedef enum logic [1:0] {
    FETCH_REQ   = 2'd0,
    FETCH_HOLD  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Instruction addresses are word addresses; the low two bits carry no meaning.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  // Sequential successor, wrapping modulo 2^32.
  function automatic logic [31:0] pc_plus_step(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry output buffer plus one-entry skid register
module fetch_skid_buf
  import if_fetch_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_resetn,
  input  logic        i_clear,       // empty the output buffer
  input  logic        i_load,        // buffer <- incoming word
  input  logic        i_promote,     // buffer <- skid word
  input  logic        i_skid_load,   // skid <- incoming word
  input  logic        i_skid_clear,  // discard the skid word
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc4,
  output logic        o_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc4
);

  logic        r_buf_valid;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc4;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc4;

  // Output buffer: clear wins so a redirect can never leave a stale word visible.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_buf_valid <= 1'b0;
      r_buf_instr <= NOP_INSTR;
      r_buf_pc4   <= 32'h0;
    end else if (i_clear) begin
      r_buf_valid <= 1'b0;
    end else if (i_load) begin
      r_buf_valid <= 1'b1;
      r_buf_instr <= i_instr;
      r_buf_pc4   <= i_pc4;
    end else if (i_promote) begin
      r_buf_valid <= 1'b1;
      r_buf_instr <= r_skid_instr;
      r_buf_pc4   <= r_skid_pc4;
    end
  end

  // Skid register: catches the word that completes while the buffer is stalled.
  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'h0;
    end else if (i_skid_clear) begin
      r_skid_instr <= NOP_INSTR;
      r_skid_pc4   <= 32'h0;
    end else if (i_skid_load) begin
      r_skid_instr <= i_instr;
      r_skid_pc4   <= i_pc4;
    end
  end

  assign o_valid = r_buf_valid;
  assign o_instr = r_buf_valid ? r_buf_instr : NOP_INSTR;
  assign o_pc4   = r_buf_valid ? r_buf_pc4 : 32'h0;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, imem handshake, stall and redirect
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        keep,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] fetch_instruction,
  output logic [31:0] IF_PCjia4,
  output logic        fetch_valid
);

  localparam logic [31:0] RESET_PC_ALIGNED = word_align(RESET_PC);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending_pc;

  logic        w_buf_valid;
  logic [31:0] w_buf_instr;
  logic [31:0] w_buf_pc4;
  logic        w_free;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  logic        w_buf_clear;
  logic        w_buf_load;
  logic        w_buf_promote;
  logic        w_skid_load;
  logic        w_skid_clear;

  // The buffer can take a new word when it is empty or IF/ID consumes it this edge.
  assign w_free   = !w_buf_valid || !keep;
  assign w_target = word_align(redirect_pc);
  assign w_pc4    = pc_plus_step(r_pc);

  // Buffer/skid steering; a redirect flushes both regardless of keep.
  always_comb begin
    w_buf_clear   = 1'b0;
    w_buf_load    = 1'b0;
    w_buf_promote = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_clear  = 1'b0;
    if (redirect) begin
      w_buf_clear  = 1'b1;
      w_skid_clear = 1'b1;
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (imem_ready && w_free) begin
            w_buf_load = 1'b1;
          end else if (imem_ready) begin
            w_skid_load = 1'b1;
          end else if (w_free) begin
            w_buf_clear = 1'b1;
          end
        end
        FETCH_HOLD: begin
          if (!keep) begin
            w_buf_promote = 1'b1;
          end
        end
        FETCH_DRAIN: begin
          w_buf_clear = 1'b1;
        end
        default: begin
          w_buf_clear = 1'b1;
        end
      endcase
    end
  end

  // Fetch FSM and PC: reset > redirect > normal sequencing.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= FETCH_REQ;
      r_pc         <= RESET_PC_ALIGNED;
      r_pending_pc <= RESET_PC_ALIGNED;
    end else if (redirect) begin
      case (r_state)
        FETCH_REQ: begin
          if (imem_ready) begin
            r_pc    <= w_target;
            r_state <= FETCH_REQ;
          end else begin
            // Request already on the bus: keep its address until it completes.
            r_pending_pc <= w_target;
            r_state      <= FETCH_DRAIN;
          end
        end
        FETCH_HOLD: begin
          r_pc    <= w_target;
          r_state <= FETCH_REQ;
        end
        FETCH_DRAIN: begin
          if (imem_ready) begin
            r_pc    <= w_target;
            r_state <= FETCH_REQ;
          end else begin
            r_pending_pc <= w_target;
          end
        end
        default: begin
          r_pc    <= w_target;
          r_state <= FETCH_REQ;
        end
      endcase
    end else begin
      case (r_state)
        FETCH_REQ: begin
          if (imem_ready) begin
            r_pc <= w_pc4;
            if (!w_free) begin
              r_state <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!keep) begin
            r_state <= FETCH_REQ;
          end
        end
        FETCH_DRAIN: begin
          if (imem_ready) begin
            r_pc    <= r_pending_pc;
            r_state <= FETCH_REQ;
          end
        end
        default: begin
          r_state <= FETCH_REQ;
        end
      endcase
    end
  end

  fetch_skid_buf u_skid_buf (
    .i_clk        (clk),
    .i_resetn     (reset),
    .i_clear      (w_buf_clear),
    .i_load       (w_buf_load),
    .i_promote    (w_buf_promote),
    .i_skid_load  (w_skid_load),
    .i_skid_clear (w_skid_clear),
    .i_instr      (imem_rdata),
    .i_pc4        (w_pc4),
    .o_valid      (w_buf_valid),
    .o_instr      (w_buf_instr),
    .o_pc4        (w_buf_pc4)
  );

  // Reset also resets imem, so the request is simply dropped while reset is low.
  assign imem_req          = reset && (r_state != FETCH_HOLD);
  assign imem_addr         = r_pc;
  assign fetch_valid       = reset && w_buf_valid;
  assign fetch_instruction = fetch_valid ? w_buf_instr : NOP_INSTR;
  assign IF_PCjia4         = fetch_valid ? w_buf_pc4 : 32'h0;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - self-checking bench for if_fetch_unit with a queue-level model
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        keep;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] fetch_instruction;
  logic [31:0] IF_PCjia4;
  logic        fetch_valid;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .reset             (reset),
    .keep              (keep),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .imem_rdata        (imem_rdata),
    .fetch_instruction (fetch_instruction),
    .IF_PCjia4         (IF_PCjia4),
    .fetch_valid       (fetch_valid)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: fetched-but-unconsumed words (at most two), next fetch address,
  // and whether the in-flight request is stale after a redirect.
  logic [31:0] q_instr[$];
  logic [31:0] q_pc4[$];
  logic [31:0] m_addr;
  logic [31:0] m_pend;
  bit          m_disc;
  bit          m_known;

  // Memory: cfg_wait < 0 picks 0..2 wait states per request at random.
  int cfg_wait;
  bit mem_busy;
  int wait_left;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_instr;
  logic [31:0] s_pc4;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rs, input bit k, input bit rd, input logic [31:0] rpc);
    bit          exp_req;
    bit          exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
    bit          done;
    @(negedge clk);
    reset       = rs;
    keep        = k;
    redirect    = rd;
    redirect_pc = rpc;
    #1;
    if (imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy  = 1'b1;
        wait_left = (cfg_wait < 0) ? int'($urandom_range(0, 2)) : cfg_wait;
      end
      imem_ready = (wait_left == 0);
      imem_rdata = imem_ready ? memf(imem_addr) : $urandom;
    end else begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
    end
    #1;
    s_req   = imem_req;
    s_valid = fetch_valid;
    s_addr  = imem_addr;
    s_instr = fetch_instruction;
    s_pc4   = IF_PCjia4;
    exp_req   = rs && (m_disc || q_instr.size() < 2);
    exp_valid = rs && (q_instr.size() > 0);
    exp_instr = exp_valid ? q_instr[0] : 32'h0;
    exp_pc4   = exp_valid ? q_pc4[0] : 32'h0;
    if (!rs) begin
      chk("rst_req", {31'h0, s_req}, 32'h0);
      chk("rst_valid", {31'h0, s_valid}, 32'h0);
      chk("rst_instr", s_instr, 32'h0);
      chk("rst_pc4", s_pc4, 32'h0);
    end else if (m_known) begin
      chk("model_req", {31'h0, s_req}, {31'h0, exp_req});
      chk("model_addr", s_addr, m_addr);
      chk("model_valid", {31'h0, s_valid}, {31'h0, exp_valid});
      chk("model_instr", s_instr, exp_instr);
      chk("model_pc4", s_pc4, exp_pc4);
    end
    done = exp_req && imem_ready;
    @(posedge clk);
    if (!rs) mem_busy = 1'b0;
    else if (s_req && imem_ready) mem_busy = 1'b0;
    else if (s_req && mem_busy) wait_left--;
    if (!rs) begin
      q_instr.delete();
      q_pc4.delete();
      m_addr  = RST_PC;
      m_pend  = RST_PC;
      m_disc  = 1'b0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (rd) begin
        q_instr.delete();
        q_pc4.delete();
        if (exp_req && !imem_ready) begin
          m_disc = 1'b1;
          m_pend = rpc & 32'hFFFF_FFFC;
        end else begin
          m_addr = rpc & 32'hFFFF_FFFC;
          m_disc = 1'b0;
        end
      end else begin
        if (q_instr.size() > 0 && !k) begin
          void'(q_instr.pop_front());
          void'(q_pc4.pop_front());
        end
        if (done) begin
          if (m_disc) begin
            m_addr = m_pend;
            m_disc = 1'b0;
          end else begin
            q_instr.push_back(memf(m_addr));
            q_pc4.push_back(m_addr + 32'd4);
            m_addr = m_addr + 32'd4;
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0; keep = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    cfg_wait = 0; mem_busy = 1'b0; wait_left = 0;
    m_known = 1'b0; m_disc = 1'b0; m_addr = 32'h0; m_pend = 32'h0;

    // Reset, then zero-wait streaming.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("lit_rst_req", {31'h0, s_req}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_a_addr", s_addr, 32'h0);
    chk("lit_a_valid", {31'h0, s_valid}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_b_addr", s_addr, 32'h4);
    chk("lit_b_pc4", s_pc4, 32'h4);
    chk("lit_b_valid", {31'h0, s_valid}, 32'h1);
    chk("lit_b_instr", s_instr, memf(32'h0));
    cycle(1, 0, 0, 0);
    chk("lit_c_addr", s_addr, 32'h8);
    chk("lit_c_pc4", s_pc4, 32'h8);

    // keep for three cycles with the buffer full.
    cycle(1, 1, 0, 0);
    chk("lit_d_pc4", s_pc4, 32'hC);
    chk("lit_d_req", {31'h0, s_req}, 32'h1);
    cycle(1, 1, 0, 0);
    chk("lit_e_req", {31'h0, s_req}, 32'h0);
    chk("lit_e_pc4", s_pc4, 32'hC);
    chk("lit_e_addr", s_addr, 32'h10);
    cycle(1, 1, 0, 0);
    chk("lit_f_pc4", s_pc4, 32'hC);
    cycle(1, 0, 0, 0);
    chk("lit_g_pc4", s_pc4, 32'hC);
    cycle(1, 0, 0, 0);
    chk("lit_h_pc4", s_pc4, 32'h10);
    chk("lit_h_instr", s_instr, memf(32'hC));
    chk("lit_h_addr", s_addr, 32'h10);
    cycle(1, 0, 0, 0);
    chk("lit_i_pc4", s_pc4, 32'h14);

    // 2-wait memory, redirect in the first wait cycle.
    cfg_wait = 2;
    cycle(1, 0, 1, 32'h100);
    chk("lit_j_addr", s_addr, 32'h18);
    cycle(1, 0, 0, 0);
    chk("lit_k_addr", s_addr, 32'h18);
    chk("lit_k_valid", {31'h0, s_valid}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_l_addr", s_addr, 32'h18);
    chk("lit_l_valid", {31'h0, s_valid}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_m_addr", s_addr, 32'h100);
    chk("lit_m_valid", {31'h0, s_valid}, 32'h0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    chk("lit_p_pc4", s_pc4, 32'h104);
    chk("lit_p_valid", {31'h0, s_valid}, 32'h1);

    // Reach HOLD, then redirect with keep held.
    cfg_wait = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(1, 1, 0, 0);
      if (s_req === 1'b0) break;
    end
    chk("lit_hold_reached", {31'h0, s_req}, 32'h0);
    cycle(1, 1, 1, 32'h200);
    cycle(1, 0, 0, 0);
    chk("lit_q_valid", {31'h0, s_valid}, 32'h0);
    chk("lit_q_instr", s_instr, 32'h0);
    chk("lit_q_pc4", s_pc4, 32'h0);
    chk("lit_q_addr", s_addr, 32'h200);
    cycle(1, 0, 0, 0);
    chk("lit_q2_pc4", s_pc4, 32'h204);

    // Two redirects during one drain: the later target wins.
    cfg_wait = 2;
    cycle(1, 0, 1, 32'h300);
    chk("lit_r1_addr", s_addr, 32'h208);
    cycle(1, 0, 1, 32'h400);
    chk("lit_r2_addr", s_addr, 32'h208);
    cycle(1, 0, 0, 0);
    chk("lit_r3_addr", s_addr, 32'h208);
    cycle(1, 0, 0, 0);
    chk("lit_r4_addr", s_addr, 32'h400);
    chk("lit_r4_valid", {31'h0, s_valid}, 32'h0);

    // Redirect to the top word (low bits ignored) and wrap.
    cfg_wait = 0;
    repeat (4) cycle(1, 0, 0, 0);
    cycle(1, 0, 1, 32'hFFFF_FFFF);
    cycle(1, 0, 0, 0);
    chk("lit_s2_addr", s_addr, 32'hFFFF_FFFC);
    chk("lit_s2_valid", {31'h0, s_valid}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_s3_addr", s_addr, 32'h0);
    chk("lit_s3_pc4", s_pc4, 32'h0);
    chk("lit_s3_valid", {31'h0, s_valid}, 32'h1);
    chk("lit_s3_instr", s_instr, memf(32'hFFFF_FFFC));

    // Reset in the middle of a waiting request.
    cfg_wait = 2;
    cycle(1, 0, 0, 0);
    chk("lit_t_req", {31'h0, s_req}, 32'h1);
    cycle(0, 0, 0, 0);
    chk("lit_t2_req", {31'h0, s_req}, 32'h0);
    cycle(1, 0, 0, 0);
    chk("lit_t3_req", {31'h0, s_req}, 32'h1);
    chk("lit_t3_addr", s_addr, RST_PC);
    chk("lit_t3_valid", {31'h0, s_valid}, 32'h0);

    // Randomized traffic against the model.
    cfg_wait = -1;
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0),
            ($urandom_range(0, 99) < 30),
            ($urandom_range(0, 99) < 8),
            $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
